// File: rtl/telem_pkt_if.sv
// Packet-side bus of telem_pkt: snapshot inputs, UART byte handshake, status.
// master drives the request side; slave is the packetizer.
interface telem_pkt_if;
    logic        snap;
    logic [15:0] lft_spd;
    logic [15:0] rght_spd;
    logic [15:0] ptch;
    logic [11:0] batt;
    logic        tx_done;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        busy;
    logic        pkt_done;

    modport master (
        output snap, lft_spd, rght_spd, ptch, batt, tx_done,
        input  trmt, tx_data, busy, pkt_done
    );

    modport slave (
        input  snap, lft_spd, rght_spd, ptch, batt, tx_done,
        output trmt, tx_data, busy, pkt_done
    );
endinterface

// File: rtl/telem_pkt.sv
// Telemetry packetizer: snapshots wheel speeds, pitch and battery, then feeds a UART one byte at a time.
// Define TELEM_CHKSUM_EN to append a two's-complement checksum byte (11 bytes instead of 10).
module telem_pkt (
    input  logic       clk,
    input  logic       rst,
    telem_pkt_if.slave bus
);
`ifdef TELEM_CHKSUM_EN
    localparam logic [3:0] NBYTES = 4'd11;
`else
    localparam logic [3:0] NBYTES = 4'd10;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, GUARD} state_t;

    typedef struct packed {
        logic [15:0] lft;
        logic [15:0] rght;
        logic [15:0] ptch;
        logic [11:0] batt;
    } snap_t;

    state_t     state, state_nxt;
    snap_t      snp, snp_nxt;
    logic [3:0] byte_idx, idx_nxt;
    logic       trmt, trmt_nxt;
    logic [7:0] tx_data, data_nxt;
    logic       busy, busy_nxt;
    logic       pkt_done, pd_nxt;
    logic [7:0] cur_byte;

`ifdef TELEM_CHKSUM_EN
    logic [7:0] pay_sum;
    logic [7:0] chk;
    assign pay_sum = snp.lft[15:8] + snp.lft[7:0] + snp.rght[15:8] + snp.rght[7:0]
                   + snp.ptch[15:8] + snp.ptch[7:0] + {4'b0000, snp.batt[11:8]} + snp.batt[7:0];
    assign chk = 8'h00 - pay_sum;
`endif

    always_comb begin
        cur_byte = 8'h00;
        case (byte_idx)
            4'd0:  cur_byte = 8'hAA;
            4'd1:  cur_byte = 8'h55;
            4'd2:  cur_byte = snp.lft[15:8];
            4'd3:  cur_byte = snp.lft[7:0];
            4'd4:  cur_byte = snp.rght[15:8];
            4'd5:  cur_byte = snp.rght[7:0];
            4'd6:  cur_byte = snp.ptch[15:8];
            4'd7:  cur_byte = snp.ptch[7:0];
            4'd8:  cur_byte = {4'b0000, snp.batt[11:8]};
            4'd9:  cur_byte = snp.batt[7:0];
`ifdef TELEM_CHKSUM_EN
            4'd10: cur_byte = chk;
`endif
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_nxt = state;
        snp_nxt   = snp;
        idx_nxt   = byte_idx;
        trmt_nxt  = 1'b0;
        data_nxt  = tx_data;
        busy_nxt  = busy;
        pd_nxt    = 1'b0;
        case (state)
            IDLE: begin
                // The pkt_done cycle is already IDLE; a snap there must not start a new packet.
                if (bus.snap && !pkt_done) begin
                    snp_nxt   = '{lft: bus.lft_spd, rght: bus.rght_spd,
                                  ptch: bus.ptch, batt: bus.batt};
                    idx_nxt   = 4'd0;
                    busy_nxt  = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.tx_done) begin
                    if (byte_idx < NBYTES) begin
                        trmt_nxt  = 1'b1;
                        data_nxt  = cur_byte;
                        idx_nxt   = byte_idx + 4'd1;
                        state_nxt = GUARD;
                    end else begin
                        pd_nxt    = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            // UART drops tx_done one cycle after trmt, so skip that stale sample.
            GUARD:   state_nxt = WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            snp      <= '0;
            byte_idx <= 4'd0;
            trmt     <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            pkt_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            snp      <= snp_nxt;
            byte_idx <= idx_nxt;
            trmt     <= trmt_nxt;
            tx_data  <= data_nxt;
            busy     <= busy_nxt;
            pkt_done <= pd_nxt;
        end
    end

    assign bus.trmt     = trmt;
    assign bus.tx_data  = tx_data;
    assign bus.busy     = busy;
    assign bus.pkt_done = pkt_done;
endmodule

// File: tb/tb_telem_pkt.sv
// Directed bench for telem_pkt: table of packets plus hand-written stall, re-snap and reset sequences.
// Build with or without TELEM_CHKSUM_EN; expected byte count follows the macro.
module tb_telem_pkt;
`ifdef TELEM_CHKSUM_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] p;
        logic [11:0] b;
        logic [87:0] exp;   // byte 0 in the top bits, CHK last
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold_low = 1'b0;
    int   tx_cnt = 0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   pd_cnt = 0;
    logic prev_trmt = 1'b0;
    logic [7:0] got[$];
    int   got_cyc[$];
    vec_t vecs[4];

    telem_pkt_if bus();

    telem_pkt dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UART model: tx_done falls the cycle after trmt and stays low 20 cycles.
    always @(posedge clk) begin
        if (bus.trmt) tx_cnt <= 20;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end
    assign bus.tx_done = (tx_cnt == 0) && !hold_low;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.trmt) begin
            got.push_back(bus.tx_data);
            got_cyc.push_back(cyc);
            chk("trmt_back_to_back", {31'd0, prev_trmt}, 32'd0);
        end
        if (bus.pkt_done) pd_cnt++;
        prev_trmt = bus.trmt;
    end

    task automatic set_in(input int vi);
        bus.lft_spd  = vecs[vi].l;
        bus.rght_spd = vecs[vi].r;
        bus.ptch     = vecs[vi].p;
        bus.batt     = vecs[vi].b;
    endtask

    task automatic pulse_snap(output int snap_cyc);
        @(posedge clk); #1;
        got.delete(); got_cyc.delete(); pd_cnt = 0;
        bus.snap = 1'b1;
        snap_cyc = cyc;
        @(posedge clk); #1;
        bus.snap = 1'b0;
    endtask

    task automatic wait_pd(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.pkt_done && n < 2000) begin @(negedge clk); n++; end
        chk($sformatf("%s_pkt_done_seen", tag), {31'd0, bus.pkt_done}, 32'd1);
        chk($sformatf("%s_busy_at_done", tag), {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic cmp_stream(input int vi, input string tag);
        logic [31:0] a;
        repeat (2) @(negedge clk);
        chk($sformatf("%s_nbytes", tag), got.size(), NB);
        for (int k = 0; k < NB; k++) begin
            a = (k < got.size()) ? {24'd0, got[k]} : 32'hDEAD;
            chk($sformatf("%s_byte%0d", tag, k), a, {24'd0, vecs[vi].exp[87-8*k -: 8]});
        end
        chk($sformatf("%s_pkt_done_pulses", tag), pd_cnt, 1);
        chk($sformatf("%s_busy_after", tag), {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int sc, n, rel;
        vecs[0] = '{16'h1234, 16'hFFFE, 16'h0100, 12'hABC, 88'hAA55_1234_FFFE_0100_0ABC_F6};
        vecs[1] = '{16'h0000, 16'h0000, 16'h0000, 12'h000, 88'hAA55_0000_0000_0000_0000_00};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 12'hFFF, 88'hAA55_FFFF_FFFF_FFFF_0FFF_F8};
        vecs[3] = '{16'h8001, 16'h7F80, 16'h00FF, 12'h123, 88'hAA55_8001_7F80_00FF_0123_5D};
        bus.snap = 1'b0;
        set_in(0);

        // Reset state, with a snap pending to show it is ignored under reset.
        bus.snap = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_trmt", {31'd0, bus.trmt}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_pkt_done", {31'd0, bus.pkt_done}, 32'd0);
        chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
        bus.snap = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // Table: full packets, with first-byte latency check.
        for (int vi = 0; vi < 4; vi++) begin
            set_in(vi);
            pulse_snap(sc);
            wait_pd($sformatf("vec%0d", vi));
            cmp_stream(vi, $sformatf("vec%0d", vi));
            chk($sformatf("vec%0d_latency", vi),
                (got_cyc.size() > 0) ? got_cyc[0] - sc : -1, 2);
        end

        // Re-snap mid-packet and through the pkt_done cycle with changed inputs.
        set_in(0);
        pulse_snap(sc);
        n = 0;
        while (got.size() < 3 && n < 2000) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        set_in(2);
        bus.snap = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.pkt_done && n < 2000) begin @(negedge clk); n++; end
        chk("resnap_pkt_done_seen", {31'd0, bus.pkt_done}, 32'd1);
        @(posedge clk); #1;
        bus.snap = 1'b0;
        cmp_stream(0, "resnap");
        n = 0;
        repeat (60) begin @(negedge clk); if (bus.trmt) n++; end
        chk("resnap_no_second_pkt", n, 0);
        chk("resnap_idle_busy", {31'd0, bus.busy}, 32'd0);

        // tx_done low when snap is accepted: stall, then first byte one cycle after release.
        @(posedge clk); #1;
        hold_low = 1'b1;
        set_in(3);
        pulse_snap(sc);
        n = 0;
        repeat (10) begin @(negedge clk); if (bus.trmt) n++; end
        chk("stall_no_trmt", n, 0);
        chk("stall_busy", {31'd0, bus.busy}, 32'd1);
        @(posedge clk); #1;
        hold_low = 1'b0;
        rel = cyc;
        n = 0;
        @(negedge clk);
        while (got.size() == 0 && n < 50) begin @(negedge clk); n++; end
        chk("stall_release_lat", (got_cyc.size() > 0) ? got_cyc[0] - rel : -1, 1);
        chk("stall_first_byte", (got.size() > 0) ? {24'd0, got[0]} : 32'hDEAD, 32'hAA);
        wait_pd("stall");
        cmp_stream(3, "stall");

        // Reset after the 4th byte aborts the packet.
        set_in(0);
        pulse_snap(sc);
        n = 0;
        while (got.size() < 4 && n < 2000) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_trmt", {31'd0, bus.trmt}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_tx_data", {24'd0, bus.tx_data}, 32'd0);
        n = 0;
        repeat (100) begin @(negedge clk); if (bus.trmt) n++; end
        chk("abort_no_trmt", n, 0);
        chk("abort_busy_idle", {31'd0, bus.busy}, 32'd0);

        // Fresh packet after the abort.
        set_in(1);
        pulse_snap(sc);
        wait_pd("recover");
        cmp_stream(1, "recover");
        chk("recover_latency", (got_cyc.size() > 0) ? got_cyc[0] - sc : -1, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/telem_pkt.md
TELEM_PKT -- requirements
Module: telem_pkt

Interface
REQ-001 The block SHALL have one clock and one reset; the reset is synchronous and active-high.
REQ-002 The ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- snap  in  1  one-cycle request to capture and send one telemetry packet.
- lft_spd  in  16  left wheel speed, captured on accepted snap.
- rght_spd  in  16  right wheel speed, captured on accepted snap.
- ptch  in  16  pitch, captured on accepted snap.
- batt  in  12  battery level, captured on accepted snap.
- tx_done  in  1  from the downstream UART transmitter; high when idle or finished, held high.
- trmt  out  1  one-cycle pulse to the transmitter to start one byte.
- tx_data  out  8  byte for the transmitter; valid on the trmt cycle, held until the next trmt.
- busy  out  1  high from accepted snap until packet completion.
- pkt_done  out  1  one-cycle pulse when the last byte is finished.

Function
REQ-003 The packet byte order SHALL be: 0xAA, 0x55, lft_spd[15:8], lft_spd[7:0], rght_spd[15:8], rght_spd[7:0], ptch[15:8], ptch[7:0], {4'b0000,batt[11:8]}, batt[7:0], CHK.
REQ-004 CHK SHALL equal (0x100 - (8-bit sum of the 8 payload bytes)) mod 256; payload plus CHK then sums to 0x00 mod 256.
REQ-005 The FSM SHALL have three states: IDLE, WAIT, GUARD.
REQ-006 In IDLE, snap=1 SHALL capture all four inputs into snapshot registers, clear byte_idx, set busy=1 and enter WAIT on the next edge. Snapshot contents SHALL NOT change until the next accepted snap.
REQ-007 In WAIT with tx_done=1 and byte_idx < NBYTES, the block SHALL, registered on the same edge: set trmt=1, load tx_data with byte[byte_idx], increment byte_idx and enter GUARD.
REQ-008 GUARD SHALL last exactly one cycle, drive trmt=0 and ignore tx_done, then return to WAIT. This covers the transmitter's one-cycle lag in dropping tx_done.
REQ-009 In WAIT with tx_done=1 and byte_idx == NBYTES, the block SHALL pulse pkt_done=1 for one cycle, clear busy and enter IDLE.
REQ-010 In WAIT with tx_done=0, the block SHALL stall with all outputs unchanged.
REQ-011 Latency SHALL be as follows: snap in cycle N with tx_done high gives trmt high in cycle N+2 with tx_data=0xAA.
REQ-012 snap SHALL be ignored in any state other than IDLE, including the cycle pkt_done is high. Such a snap causes no capture and no queued request.
REQ-013 trmt SHALL never be high in two consecutive cycles.
REQ-014 byte_idx SHALL be 4 bits wide and SHALL NOT wrap; its maximum value is NBYTES.

Reset
REQ-015 rst=1 at a clock edge SHALL force the following in the next cycle: state IDLE, trmt=0, tx_data=0x00, busy=0, pkt_done=0, byte_idx=0, snapshot registers 0.
REQ-016 rst SHALL abort a packet mid-transfer; no further trmt occurs until a new snap is accepted after rst is released.

Configuration
REQ-017 With macro TELEM_CHKSUM_EN defined, NBYTES SHALL be 11 and CHK SHALL be sent as the last byte.
REQ-018 Without TELEM_CHKSUM_EN, NBYTES SHALL be 10, no CHK byte is sent, and no checksum logic is present.

Verification
REQ-019 The bench SHALL cover these scenarios.
- Scenario 1 (TELEM_CHKSUM_EN defined, transmitter model holds tx_done low 20 cycles after each trmt): lft_spd=0x1234, rght_spd=0xFFFE, ptch=0x0100, batt=0xABC, snap -> byte stream AA 55 12 34 FF FE 01 00 0A BC F6, then exactly one pkt_done pulse, then busy=0.
- Scenario 2 (TELEM_CHKSUM_EN not defined): same stimulus as scenario 1 -> 10 bytes ending 0A BC, with no F6 byte.
- Scenario 3: snap asserted again mid-packet and in the pkt_done cycle -> no restart and no second packet; snapshot values unchanged.
- Scenario 4: tx_done held low when snap is accepted -> no trmt until tx_done rises, then trmt within 1 cycle with tx_data=0xAA.
- Scenario 5: rst asserted after the 4th trmt -> trmt, busy and tx_data read 0/0/0x00 next cycle; no further trmt until a new snap is accepted.
- Scenario 6: all inputs 0x0000/0x000, TELEM_CHKSUM_EN defined -> CHK=0x00; trmt never high in consecutive cycles.
